// File: rtl/spi_pwm_regbank.sv
// PWM register bank fed by decoded SPI writes: staging registers, period-boundary
// shadow loads, prescaled counter and NUM_CH registered PWM outputs.
module spi_pwm_regbank #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_tick
);

  localparam logic [ADDR_W-1:0] A_CTRL     = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_PRESCALE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_PERIOD   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_STATUS   = ADDR_W'(3);

  logic [1:0]       r_ctrl;
  logic [WIDTH-1:0] r_prescale;
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_duty [NUM_CH];
  logic [WIDTH-1:0] r_prescale_act;
  logic [WIDTH-1:0] r_period_act;
  logic [WIDTH-1:0] r_duty_act [NUM_CH];
  logic [WIDTH-1:0] r_pre_cnt;
  logic [WIDTH-1:0] r_cnt;
  logic [NUM_CH-1:0] r_pwm;
  logic             r_period_tick;
  logic [WIDTH-1:0] w_rd_data;

  logic w_en;
  logic w_pol;
  logic w_tick;
  assign w_en   = r_ctrl[0];
  assign w_pol  = r_ctrl[1];
  assign w_tick = (r_pre_cnt == r_prescale_act);

  // Staging register writes from the SPI slave; STATUS and unmapped addresses are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ctrl     <= 2'b00;
      r_prescale <= '0;
      r_period   <= '1;
      for (int i = 0; i < NUM_CH; i++) r_duty[i] <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        A_CTRL:     r_ctrl     <= wr_data[1:0];
        A_PRESCALE: r_prescale <= wr_data;
        A_PERIOD:   r_period   <= wr_data;
        default:    ;
      endcase
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_addr == ADDR_W'(4 + i)) r_duty[i] <= wr_data;
      end
    end
  end

  // Prescaler, period counter and shadow loads at each wrap (or continuously while idle).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prescale_act <= '0;
      r_period_act   <= '1;
      for (int i = 0; i < NUM_CH; i++) r_duty_act[i] <= '0;
      r_pre_cnt      <= '0;
      r_cnt          <= '0;
      r_period_tick  <= 1'b0;
    end else if (!w_en) begin
      r_prescale_act <= r_prescale;
      r_period_act   <= r_period;
      r_duty_act     <= r_duty;
      r_pre_cnt      <= '0;
      r_cnt          <= '0;
      r_period_tick  <= 1'b0;
    end else begin
      r_period_tick <= w_tick && (r_cnt == r_period_act);
      if (w_tick) begin
        r_pre_cnt <= '0;
        if (r_cnt == r_period_act) begin
          r_cnt          <= '0;
          r_prescale_act <= r_prescale;
          r_period_act   <= r_period;
          r_duty_act     <= r_duty;
        end else begin
          r_cnt <= r_cnt + WIDTH'(1);
        end
      end else begin
        r_pre_cnt <= r_pre_cnt + WIDTH'(1);
      end
    end
  end

  // Output compare; POL is taken straight from staging so it applies without waiting for a wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pwm <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_pwm[i] <= w_en ? ((r_cnt < r_duty_act[i]) ^ w_pol) : w_pol;
      end
    end
  end

  // Combinational read mux driving MISO shift-out.
  always_comb begin
    w_rd_data = '0;
    case (rd_addr)
      A_CTRL:     w_rd_data = {{(WIDTH-2){1'b0}}, r_ctrl};
      A_PRESCALE: w_rd_data = r_prescale;
      A_PERIOD:   w_rd_data = r_period;
      A_STATUS:   w_rd_data = r_cnt;
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          w_rd_data = w_rd_data | ((rd_addr == ADDR_W'(4 + i)) ? r_duty[i] : '0);
        end
      end
    endcase
  end

  assign rd_data     = w_rd_data;
  assign pwm_out     = r_pwm;
  assign period_tick = r_period_tick;

endmodule

// File: tb/tb_spi_pwm_regbank.sv
// Directed + randomized bench for spi_pwm_regbank against a position-in-period reference model.
module tb_spi_pwm_regbank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic [3:0] pwm_out;
  logic       period_tick;

  spi_pwm_regbank #(.NUM_CH(4), .WIDTH(8), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .pwm_out(pwm_out), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int h0, h1, h2, tk;

  // Reference model: staging values, active copies and the clock position within the period.
  int m_ctrl, m_pre, m_per, m_pre_a, m_per_a, m_pos;
  int m_duty [4];
  int m_duty_a [4];
  logic [3:0] m_pwm;
  logic m_tk;

  logic [7:0] rst_tab [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_load();
    m_pre_a = m_pre;
    m_per_a = m_per;
    for (int i = 0; i < 4; i++) m_duty_a[i] = m_duty[i];
  endtask

  task automatic model_edge();
    int cnt;
    bit en, pol;
    if (!rst_n) begin
      m_ctrl = 0; m_pre = 0; m_per = 255;
      for (int i = 0; i < 4; i++) m_duty[i] = 0;
      model_load();
      m_pos = 0; m_pwm = 4'h0; m_tk = 1'b0;
    end else begin
      en  = m_ctrl[0];
      pol = m_ctrl[1];
      cnt = m_pos / (m_pre_a + 1);
      for (int i = 0; i < 4; i++) m_pwm[i] = en ? ((cnt < m_duty_a[i]) ^ pol) : pol;
      if (en) begin
        if (m_pos + 1 == (m_pre_a + 1) * (m_per_a + 1)) begin
          m_pos = 0; model_load(); m_tk = 1'b1;
        end else begin
          m_pos = m_pos + 1; m_tk = 1'b0;
        end
      end else begin
        m_pos = 0; model_load(); m_tk = 1'b0;
      end
      if (wr_en) begin
        case (int'(wr_addr))
          0: m_ctrl = int'(wr_data) & 3;
          1: m_pre = int'(wr_data);
          2: m_per = int'(wr_data);
          4, 5, 6, 7: m_duty[int'(wr_addr) - 4] = int'(wr_data);
          default: ;
        endcase
      end
    end
  endtask

  function automatic int model_read(input int a);
    case (a)
      0: return m_ctrl;
      1: return m_pre;
      2: return m_per;
      3: return m_pos / (m_pre_a + 1);
      4, 5, 6, 7: return m_duty[a - 4];
      default: return 0;
    endcase
  endfunction

  task automatic cyc_rd(input logic [3:0] a);
    @(posedge clk);
    model_edge();
    #1;
    chk("pwm_out", 32'(pwm_out), 32'(m_pwm));
    chk("period_tick", 32'(period_tick), 32'(m_tk));
    rd_addr = a;
    #1;
    chk("rd_data", 32'(rd_data), 32'(model_read(int'(a))));
    h0 += int'(pwm_out[0]);
    h1 += int'(pwm_out[1]);
    h2 += int'(pwm_out[2]);
    tk += int'(period_tick);
  endtask

  task automatic cyc();
    logic [3:0] a;
    a = ($urandom_range(0, 1) == 0) ? 4'd3 : 4'($urandom_range(0, 15));
    cyc_rd(a);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic clr();
    h0 = 0; h1 = 0; h2 = 0; tk = 0;
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      cyc();
      if (period_tick === 1'b1) seen = 1'b1;
    end
    chk("tick_wait", 32'(seen), 32'd1);
  endtask

  task automatic read_reset_values(input string tag);
    for (int a = 0; a < 16; a++) begin
      cyc_rd(4'(a));
      chk(tag, 32'(rd_data), 32'(rst_tab[a]));
    end
  endtask

  initial begin
    for (int a = 0; a < 16; a++) rst_tab[a] = 8'h00;
    rst_tab[2] = 8'hFF;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'd0; rd_addr = 4'd0;
    clr();

    // Reset state
    cyc(); cyc();
    rst_n = 1'b1;
    read_reset_values("reset_rd");
    chk("reset_pwm", 32'(pwm_out), 32'd0);

    // Basic PWM: period 10, duties 3 / 0 / 10
    wr(4'd2, 8'd9); wr(4'd4, 8'd3); wr(4'd5, 8'd0); wr(4'd6, 8'd10); wr(4'd1, 8'd0);
    wr(4'd0, 8'h01);
    idle(15);
    wait_tick();
    clr(); idle(10);
    chk("ch0_high", 32'(h0), 32'd3);
    chk("ch1_high", 32'(h1), 32'd0);
    chk("ch2_high", 32'(h2), 32'd10);
    chk("tick_per10", 32'(tk), 32'd1);

    // Prescaled: 20-clock period, ch0 high 8 clocks, STATUS steps every 4 clocks
    wr(4'd1, 8'd3); wr(4'd2, 8'd4); wr(4'd4, 8'd2);
    wait_tick();
    clr(); idle(20);
    chk("pre_ch0_high", 32'(h0), 32'd8);
    chk("pre_tick", 32'(tk), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      cyc_rd(4'd3);
      chk("status_step", 32'(rd_data), 32'(k / 4));
    end

    // Double-buffered duty: mid-period write, then a write landing on the wrap
    wr(4'd1, 8'd0); wr(4'd2, 8'd9); wr(4'd4, 8'd3);
    wait_tick();
    clr(); idle(4); wr(4'd4, 8'd7); idle(5);
    chk("mid_keep", 32'(h0), 32'd3);
    clr(); idle(10);
    chk("mid_next", 32'(h0), 32'd7);
    idle(9);
    wr(4'd4, 8'd2);
    chk("wrap_write_tick", 32'(period_tick), 32'd1);
    clr(); idle(10);
    chk("wrap_defer", 32'(h0), 32'd7);
    clr(); idle(10);
    chk("wrap_apply", 32'(h0), 32'd2);

    // Polarity inversion while running, then disable with POL=1
    wr(4'd0, 8'h03);
    idle(2);
    clr(); idle(10);
    chk("pol_inv_ch1", 32'(h1), 32'd10);
    chk("pol_inv_ch2", 32'(h2), 32'd0);
    wr(4'd0, 8'h02);
    cyc();
    chk("dis_pwm", 32'(pwm_out), 32'hF);
    chk("dis_tick", 32'(period_tick), 32'd0);
    rd_addr = 4'd3;
    #1;
    chk("dis_status", 32'(rd_data), 32'd0);
    clr(); idle(20);
    chk("dis_no_tick", 32'(tk), 32'd0);
    chk("dis_idle_level", 32'(h0), 32'd20);

    // Reset pulse mid-period
    wr(4'd0, 8'h01);
    idle(13);
    rst_n = 1'b0;
    cyc();
    chk("rst_pwm", 32'(pwm_out), 32'd0);
    chk("rst_tick", 32'(period_tick), 32'd0);
    rst_n = 1'b1;
    read_reset_values("rst_rd");

    // Randomized traffic against the model
    wr(4'd2, 8'd6);
    wr(4'd0, 8'h01);
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
      if ($urandom_range(0, 5) == 0) begin
        wr_en = 1'b1;
        wr_addr = 4'($urandom_range(0, 15));
        case (wr_addr)
          4'd0: wr_data = {6'($urandom), 1'($urandom), 1'($urandom_range(0, 7) != 0)};
          4'd1: wr_data = 8'($urandom_range(0, 3));
          4'd2: wr_data = 8'($urandom_range(0, 12));
          default: wr_data = 8'($urandom_range(0, 15));
        endcase
      end
      cyc();
      wr_en = 1'b0;
      rst_n = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
